fact_ctrl: RTL

- Sequencing controller, and initiator, for the Booth compute datapath in the factorial system.
- Accepts a start request with operand N and computes N! by driving the datapath's 2-bit phase code (INIT/MULT/DONE) and its multiplier and multiplicand operands.
- Consumes the datapath's op_done and 2W-bit product, and returns the final W-bit result with an overflow flag through a start/busy/done handshake.

---
 rtl/fact_ctrl_if.sv | 31 +++
 rtl/fact_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fact_ctrl_if.sv
// Bus between the factorial sequencer, its host and the Booth datapath.
// master is the controller; slave is the environment (host + datapath).
interface fact_ctrl_if #(
    parameter int W = 64
);
    // Host handshake: start is taken only while busy=0. done pulses one
    // cycle with result/overflow valid; they hold until the next run finishes.
    logic           start;
    logic [W-1:0]   n_in;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           overflow;

    // Datapath side: phase code and operands out, completion and product in.
    logic           op_done;
    logic [2*W-1:0] c_result;
    logic [1:0]     next_state;
    logic [W-1:0]   multiplier;
    logic [W-1:0]   multiplicand;

    modport master (
        input  start, n_in, op_done, c_result,
        output busy, done, result, overflow, next_state, multiplier, multiplicand
    );

    modport slave (
        output start, n_in, op_done, c_result,
        input  busy, done, result, overflow, next_state, multiplier, multiplicand
    );
endinterface

// File: rtl/fact_ctrl.sv
// Sequencer for N!: repeatedly multiplies acc by a down-counting cnt on the
// Booth datapath, stopping at cnt<=1 or when a product leaves the positive W-1 bit range.
module fact_ctrl #(
    parameter int W           = 64,
    parameter int MULT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    fact_ctrl_if.master  bus,
    output logic [2:0]   dbg_state
);
    localparam int MCW = $clog2(MULT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_INIT  = 3'd2,
        S_MULT  = 3'd3,
        S_DONE  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [1:0] PH_INIT = 2'b00;
    localparam logic [1:0] PH_MULT = 2'b01;
    localparam logic [1:0] PH_DONE = 2'b10;

    state_t         state, state_n;
    logic [W-1:0]   acc, cnt;
    logic           ovf;
    logic [MCW-1:0] mcnt;
    logic [W-1:0]   result_q;
    logic           overflow_q;

    logic           load;
    logic           cap_ok;
    logic           cap_ovf;
    logic           clr_mcnt;
    logic           inc_mcnt;
    logic           enter_fin;
    logic [1:0]     phase;
    logic           busy_c;
    logic           done_c;

    // The Booth datapath is signed: any set bit from W-1 upward means the
    // product is negative or too large to be a legal factorial result.
    logic           prod_bad;
    assign prod_bad = (bus.c_result[2*W-1:W-1] != '0);

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        cap_ok   = 1'b0;
        cap_ovf  = 1'b0;
        clr_mcnt = 1'b0;
        inc_mcnt = 1'b0;
        phase    = PH_INIT;
        busy_c   = 1'b1;
        done_c   = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    load    = 1'b1;
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                state_n = (cnt <= W'(1)) ? S_FIN : S_INIT;
            end
            S_INIT: begin
                clr_mcnt = 1'b1;
                state_n  = S_MULT;
            end
            S_MULT: begin
                phase    = PH_MULT;
                inc_mcnt = 1'b1;
                if (mcnt == MCW'(MULT_CYCLES - 1)) state_n = S_DONE;
            end
            S_DONE: begin
                phase = PH_DONE;
                if (bus.op_done) begin
                    if (prod_bad) begin
                        cap_ovf = 1'b1;
                        state_n = S_FIN;
                    end else begin
                        cap_ok  = 1'b1;
                        state_n = S_CHECK;
                    end
                end
            end
            S_FIN: begin
                done_c  = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign enter_fin = (state_n == S_FIN) && (state != S_FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            mcnt       <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                acc <= W'(1);
                cnt <= bus.n_in;
                ovf <= 1'b0;
            end else if (cap_ok) begin
                acc <= bus.c_result[W-1:0];
                cnt <= cnt - W'(1);
            end else if (cap_ovf) begin
                acc <= '0;
                ovf <= 1'b1;
            end
            if (clr_mcnt) mcnt <= '0;
            else if (inc_mcnt) mcnt <= mcnt + MCW'(1);
            // acc is cleared on the same edge as an overflow capture, so the
            // published result must take the overflow path explicitly.
            if (enter_fin) begin
                result_q   <= cap_ovf ? '0 : acc;
                overflow_q <= cap_ovf | ovf;
            end
        end
    end

    assign bus.next_state   = phase;
    assign bus.busy         = busy_c;
    assign bus.done         = done_c;
    assign bus.multiplier   = cnt;
    assign bus.multiplicand = acc;
    assign bus.result       = result_q;
    assign bus.overflow     = overflow_q;
    assign dbg_state        = state;
endmodule
